y86_execute_stage: RTL and testbench
====================================

Name: y86_execute_stage

Overview:
Execute (E) stage of the pipelined Y86-64 core. Sits between the decode pipeline register and the memory stage. Selects ALU operands, performs add/sub/and/xor with signed-overflow detection using the same semantics as the 64-bit subtractor, and owns the condition-code register. Evaluates jump/cmov conditions and drives the E->M pipeline register under stall/bubble control from the hazard unit.

Parameters:
W, 64, datapath width in bits
RNONE, 4'hF, register ID meaning "no destination"

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
E_stat  in  3  status of incoming instruction (1 AOK, 2 HLT, 3 ADR, 4 INS)
E_icode  in  4  instruction code
E_ifun  in  4  function code
E_valA  in  W  operand A from decode
E_valB  in  W  operand B from decode
E_valC  in  W  immediate/displacement
E_dstE  in  4  destination register for valE
E_dstM  in  4  destination register for memory load
m_exc  in  1  exception present in M stage; blocks CC update
W_exc  in  1  exception present in W stage; blocks CC update
M_stall  in  1  hold E->M register
M_bubble  in  1  load NOP into E->M register
e_Cnd  out  1  combinational condition result, for branch-mispredict logic
e_dstE  out  4  combinational effective dstE, for forwarding
e_valE  out  W  combinational ALU result, for forwarding
M_stat  out  3  registered
M_icode  out  4  registered
M_Cnd  out  1  registered
M_valE  out  W  registered ALU result
M_valA  out  W  registered valA passthrough
M_dstE  out  4  registered
M_dstM  out  4  registered
cc_zf  out  1  condition flag ZF
cc_sf  out  1  condition flag SF
cc_of  out  1  condition flag OF

Behaviour:
- Operand select by E_icode:
  - OPq (6): aluA = valA, aluB = valB.
  - RRMOVQ/cmovXX (2): aluA = valA, aluB = 0.
  - IRMOVQ (3): aluA = valC, aluB = 0.
  - RMMOVQ/MRMOVQ (4/5): aluA = valC, aluB = valB.
  - CALL/PUSHQ (8/A): aluA = -8, aluB = valB.
  - RET/POPQ (9/B): aluA = +8, aluB = valB.
  - All other icodes: aluA = 0, aluB = 0.
- ALU function: ifun for OPq (0 add, 1 sub, 2 and, 3 xor); add for every other icode.
  - Sub computes aluB - aluA.
  - Results wrap modulo 2^W.
- Flags:
  - ZF = (result == 0). SF = result[W-1].
  - Add OF = (aluA and aluB have the same sign) and (result sign differs).
  - Sub OF = (aluB and aluA have different signs) and (result sign differs from aluB).
  - And/xor: OF = 0.
- CC register:
  - Reset: ZF = 1, SF = 0, OF = 0.
  - Updates at clk edge only when E_icode = OPq, E_stat = AOK, !m_exc, !W_exc, !M_stall.
  - Otherwise holds.
- e_Cnd uses current (pre-update) CC:
  - ifun 0: always 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun > 6: 0.
  - Meaningful for icode 2 and 7; M_Cnd is registered for all icodes.
- e_dstE = RNONE when E_icode = 2 and !e_Cnd; else E_dstE.
- E->M register, priority reset > M_bubble > M_stall > load:
  - reset/bubble: M_stat = 1, M_icode = 1 (NOP), M_Cnd = 0, M_valE = 0, M_valA = 0, M_dstE = RNONE, M_dstM = RNONE.
  - stall: all M_* hold their values.
  - load: M_* <= stat, icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM. Latency is 1 cycle.
- Simultaneous OPq in E and exception in M/W: the result still propagates, but the CC does not change.
- Reset asserted mid-stream clears the CC and the register on that edge regardless of stall.

Optional Feature:
Y86_EXEC_MUL_EN:
- When defined, OPq ifun 4 = mulq.
  - valE = low W bits of the signed product.
  - OF = 1 when the full signed product does not fit in W bits.
  - ZF/SF are taken from the low W bits.
- When undefined, OPq with ifun > 3 forces M_stat = 4 (INS) and valE = 0, and does not update CC.
- With the macro defined, OPq ifun > 4 gets the same INS treatment.

Test Plan:
- Reset 2 cycles -> M_icode = 1, M_stat = 1, M_dstE = F, cc = {ZF1, SF0, OF0}.
- OPq sub: valA = 0xFFFFFFFFFFFFFFFE, valB = 0x7FFFFFFFFFFFFFFF -> M_valE = 0x8000000000000001 next cycle; cc ZF0, SF1, OF1.
- OPq add: valA = 3, valB = -3 -> valE = 0, ZF1, SF0, OF0. Then cmovle (icode 2, ifun 1), valA = 5, dstE = 2 -> M_dstE = 2, M_valE = 5. Then cmovne with dstE = 2 -> M_dstE = F.
- OPq xor: valA = valB = 0x55 with m_exc = 1 -> M_valE = 0; cc unchanged from the previous values.
- PUSHQ: valB = 0x100 -> M_valE = 0xF8. With M_stall = 1 for 2 cycles the M_* outputs hold, then load. Asserting M_stall and M_bubble together -> NOP loaded.
- OPq ifun 4: valA = 0x100000000, valB = 0x100000000 -> with macro, valE = 0, OF1, ZF1; without macro, M_stat = 4 and cc unchanged.

Source files
------------

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU operand select, add/sub/and/xor with overflow, CC register,
// cmov/jump condition evaluation and the E->M pipeline register. Optional mulq via Y86_EXEC_MUL_EN.
module y86_execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic         m_exc,
  input  logic         W_exc,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic         e_Cnd,
  output logic [3:0]   e_dstE,
  output logic [W-1:0] e_valE,
  output logic [2:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_INS    = 3'd4;
  localparam logic [W-1:0] PLUS8  = W'(8);
  localparam logic [W-1:0] MINUS8 = ~PLUS8 + W'(1);
`ifdef Y86_EXEC_MUL_EN
  localparam logic [3:0] OP_MAX   = 4'h4;
`else
  localparam logic [3:0] OP_MAX   = 4'h3;
`endif

  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [3:0]   alu_fun;
  logic         alu_of, alu_zf, alu_sf, op_illegal, cc_upd;
  logic [W-1:0] sum, diff;
  logic [2:0]   cc_d, cc_q;

  logic [2:0]   m_stat_d, m_stat_q;
  logic [3:0]   m_icode_d, m_icode_q, m_dste_d, m_dste_q, m_dstm_d, m_dstm_q;
  logic         m_cnd_d, m_cnd_q;
  logic [W-1:0] m_vale_d, m_vale_q, m_vala_d, m_vala_q;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode)
      I_OPQ:               begin alu_a = E_valA; alu_b = E_valB; end
      I_RRMOVQ:            begin alu_a = E_valA; alu_b = '0;     end
      I_IRMOVQ:            begin alu_a = E_valC; alu_b = '0;     end
      I_RMMOVQ, I_MRMOVQ:  begin alu_a = E_valC; alu_b = E_valB; end
      I_CALL, I_PUSHQ:     begin alu_a = MINUS8; alu_b = E_valB; end
      I_RET, I_POPQ:       begin alu_a = PLUS8;  alu_b = E_valB; end
      default:             begin alu_a = '0;     alu_b = '0;     end
    endcase
  end

  assign sum        = alu_b + alu_a;
  assign diff       = alu_b - alu_a;
  assign alu_fun    = (E_icode == I_OPQ) ? E_ifun : 4'h0;
  assign op_illegal = (E_icode == I_OPQ) && (E_ifun > OP_MAX);

`ifdef Y86_EXEC_MUL_EN
  // Sign-extended operands make the low 2W bits of an unsigned multiply equal the signed product.
  logic [2*W-1:0] prod;
  assign prod = {{W{alu_a[W-1]}}, alu_a} * {{W{alu_b[W-1]}}, alu_b};
`endif

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (alu_fun)
      4'h0: begin
        alu_res = sum;
        alu_of  = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      4'h1: begin
        alu_res = diff;
        alu_of  = (alu_b[W-1] != alu_a[W-1]) && (diff[W-1] != alu_b[W-1]);
      end
      4'h2: alu_res = alu_a & alu_b;
      4'h3: alu_res = alu_a ^ alu_b;
`ifdef Y86_EXEC_MUL_EN
      4'h4: begin
        alu_res = prod[W-1:0];
        alu_of  = (prod[2*W-1:W] != {W{prod[W-1]}});
      end
`endif
      default: begin
        alu_res = '0;
        alu_of  = 1'b0;
      end
    endcase
  end

  assign alu_zf = (alu_res == '0);
  assign alu_sf = alu_res[W-1];
  assign e_valE = alu_res;

  // Conditions read the CC as it stood before this instruction's own update.
  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'h0: e_Cnd = 1'b1;
      4'h1: e_Cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'h2: e_Cnd = cc_q[1] ^ cc_q[0];
      4'h3: e_Cnd = cc_q[2];
      4'h4: e_Cnd = ~cc_q[2];
      4'h5: e_Cnd = ~(cc_q[1] ^ cc_q[0]);
      4'h6: e_Cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

  assign cc_upd = (E_icode == I_OPQ) && !op_illegal && (E_stat == S_AOK)
                  && !m_exc && !W_exc && !M_stall;
  assign cc_d   = cc_upd ? {alu_zf, alu_sf, alu_of} : cc_q;

  always_ff @(posedge clk) begin
    if (reset) cc_q <= 3'b100;
    else       cc_q <= cc_d;
  end

  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    if (M_bubble) begin
      m_stat_d  = S_AOK;
      m_icode_d = I_NOP;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_vala_d  = '0;
      m_dste_d  = RNONE;
      m_dstm_d  = RNONE;
    end else if (!M_stall) begin
      m_stat_d  = op_illegal ? S_INS : E_stat;
      m_icode_d = E_icode;
      m_cnd_d   = e_Cnd;
      m_vale_d  = e_valE;
      m_vala_d  = E_valA;
      m_dste_d  = e_dstE;
      m_dstm_d  = E_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_stat_q  <= S_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
    end else begin
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
    end
  end

  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_Cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;
  assign cc_zf   = cc_q[2];
  assign cc_sf   = cc_q[1];
  assign cc_of   = cc_q[0];

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed scoreboard bench for y86_execute_stage; expectations follow Y86_EXEC_MUL_EN when defined.
module tb_y86_execute_stage;

  logic        clk, reset;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        m_exc, W_exc, M_stall, M_bubble;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [63:0] e_valE;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic        cc_zf, cc_sf, cc_of;

  int tests    = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        zf, sf, of;
  } exp_t;

  exp_t sb_q[$];

  y86_execute_stage #(.W(64), .RNONE(4'hF)) dut (
    .clk(clk), .reset(reset),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_exc(m_exc), .W_exc(W_exc), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_Cnd(e_Cnd), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                                input logic [3:0] de, input logic [3:0] dm);
    E_stat  = stat;
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = va;
    E_valB  = vb;
    E_valC  = vc;
    E_dstE  = de;
    E_dstM  = dm;
  endtask

  task automatic push_exp(input logic [2:0] stat, input logic [3:0] icode, input logic cnd,
                          input logic [63:0] ve, input logic [63:0] va, input logic [3:0] de,
                          input logic [3:0] dm, input logic zf, input logic sf, input logic of);
    exp_t e;
    e.stat = stat; e.icode = icode; e.cnd = cnd; e.val_e = ve; e.val_a = va;
    e.dst_e = de; e.dst_m = dm; e.zf = zf; e.sf = sf; e.of = of;
    sb_q.push_back(e);
  endtask

  task automatic check_comb(input string tag, input logic cnd, input logic [3:0] de, input logic [63:0] ve);
    #1;
    check_val({tag, ".e_Cnd"}, e_Cnd, cnd);
    check_val({tag, ".e_dstE"}, e_dstE, de);
    check_val({tag, ".e_valE"}, e_valE, ve);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    tests++;
    assert (sb_q.size() > 0) else begin
      failures++;
      $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, ".M_stat"},  M_stat,  e.stat);
      check_val({tag, ".M_icode"}, M_icode, e.icode);
      check_val({tag, ".M_Cnd"},   M_Cnd,   e.cnd);
      check_val({tag, ".M_valE"},  M_valE,  e.val_e);
      check_val({tag, ".M_valA"},  M_valA,  e.val_a);
      check_val({tag, ".M_dstE"},  M_dstE,  e.dst_e);
      check_val({tag, ".M_dstM"},  M_dstM,  e.dst_m);
      check_val({tag, ".cc_zf"},   cc_zf,   e.zf);
      check_val({tag, ".cc_sf"},   cc_sf,   e.sf);
      check_val({tag, ".cc_of"},   cc_of,   e.of);
    end
  endtask

  task automatic check_output(input string tag);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  initial begin
    reset = 1'b1; m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    apply_stimulus(3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    push_exp(3'd1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    check_now("reset");
    reset = 1'b0;

    apply_stimulus(3'd1, 4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3, 4'hF);
    check_comb("sub", 1'b1, 4'h3, 64'h8000_0000_0000_0001);
    push_exp(3'd1, 4'h6, 1'b1, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 4'hF, 1'b0, 1'b1, 1'b1);
    check_output("sub");

    apply_stimulus(3'd1, 4'h6, 4'h0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 4'h4, 4'hF);
    push_exp(3'd1, 4'h6, 1'b1, 64'h0, 64'd3, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0);
    check_output("add");

    apply_stimulus(3'd1, 4'h2, 4'h1, 64'd5, 64'h0, 64'h0, 4'h2, 4'hF);
    check_comb("cmovle", 1'b1, 4'h2, 64'd5);
    push_exp(3'd1, 4'h2, 1'b1, 64'd5, 64'd5, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
    check_output("cmovle");

    apply_stimulus(3'd1, 4'h2, 4'h4, 64'd5, 64'h0, 64'h0, 4'h2, 4'hF);
    check_comb("cmovne", 1'b0, 4'hF, 64'd5);
    push_exp(3'd1, 4'h2, 1'b0, 64'd5, 64'd5, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    check_output("cmovne");

    m_exc = 1'b1;
    apply_stimulus(3'd1, 4'h6, 4'h3, 64'h55, 64'h55, 64'h0, 4'h5, 4'hF);
    push_exp(3'd1, 4'h6, 1'b1, 64'h0, 64'h55, 4'h5, 4'hF, 1'b1, 1'b0, 1'b0);
    check_output("xor_mexc");
    m_exc = 1'b0;

    W_exc = 1'b1;
    apply_stimulus(3'd1, 4'h6, 4'h3, 64'h55, 64'hAA, 64'h0, 4'h5, 4'hF);
    push_exp(3'd1, 4'h6, 1'b1, 64'hFF, 64'h55, 4'h5, 4'hF, 1'b1, 1'b0, 1'b0);
    check_output("xor_wexc");
    W_exc = 1'b0;

    apply_stimulus(3'd1, 4'h6, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0, 4'h6, 4'hF);
    push_exp(3'd1, 4'h6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'h6, 4'hF, 1'b0, 1'b1, 1'b0);
    check_output("and");

    apply_stimulus(3'd1, 4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    push_exp(3'd1, 4'h7, 1'b1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    check_output("jl");

    apply_stimulus(3'd1, 4'h7, 4'h6, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    push_exp(3'd1, 4'h7, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    check_output("jg");

    apply_stimulus(3'd1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h9, 4'hF);
    push_exp(3'd1, 4'h3, 1'b1, 64'h1234, 64'h0, 4'h9, 4'hF, 1'b0, 1'b1, 1'b0);
    check_output("irmovq");

    apply_stimulus(3'd1, 4'h5, 4'h0, 64'h0, 64'h1000, 64'h10, 4'hF, 4'h3);
    push_exp(3'd1, 4'h5, 1'b1, 64'h1010, 64'h0, 4'hF, 4'h3, 1'b0, 1'b1, 1'b0);
    check_output("mrmovq");

    apply_stimulus(3'd1, 4'hA, 4'h0, 64'h11, 64'h100, 64'h0, 4'h4, 4'hF);
    push_exp(3'd1, 4'hA, 1'b1, 64'hF8, 64'h11, 4'h4, 4'hF, 1'b0, 1'b1, 1'b0);
    check_output("pushq");

    M_stall = 1'b1;
    apply_stimulus(3'd1, 4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h7, 4'hF);
    for (int i = 0; i < 2; i++) begin
      push_exp(3'd1, 4'hA, 1'b1, 64'hF8, 64'h11, 4'h4, 4'hF, 1'b0, 1'b1, 1'b0);
      check_output("stall_hold");
    end
    M_stall = 1'b0;
    push_exp(3'd1, 4'h6, 1'b1, 64'd2, 64'd1, 4'h7, 4'hF, 1'b0, 1'b0, 1'b0);
    check_output("stall_release");

    M_stall = 1'b1; M_bubble = 1'b1;
    apply_stimulus(3'd1, 4'hB, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'h5);
    push_exp(3'd1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    check_output("bubble");
    M_stall = 1'b0; M_bubble = 1'b0;

    apply_stimulus(3'd1, 4'h6, 4'h4, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0, 4'h8, 4'hF);
`ifdef Y86_EXEC_MUL_EN
    push_exp(3'd1, 4'h6, 1'b1, 64'h0, 64'h1_0000_0000, 4'h8, 4'hF, 1'b1, 1'b0, 1'b1);
`else
    push_exp(3'd4, 4'h6, 1'b1, 64'h0, 64'h1_0000_0000, 4'h8, 4'hF, 1'b0, 1'b0, 1'b0);
`endif
    check_output("opq_ifun4");

    M_stall = 1'b1; reset = 1'b1;
    apply_stimulus(3'd1, 4'h6, 4'h1, 64'd1, 64'd0, 64'h0, 4'h3, 4'hF);
    push_exp(3'd1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    check_output("mid_reset");
    reset = 1'b0; M_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
